// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : bus_fabric
// Brief    : Single-CPU address decoder with per-region wait states, open-bus
//            read-back and interrupt merge. Optional sticky decode-error
//            capture is enabled by defining BUS_FABRIC_DECERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fabric #(
   parameter int                      N_SLAVES = 5,
   // Lists are written highest index first so that region 0 lands in the LSBs:
   // region 0 = 8000/8000, region 1 = 0000/C000, regions 2..4 = 6000/7000/5000.
   parameter logic [16*N_SLAVES-1:0]  SLV_BASE = {16'h5000, 16'h7000, 16'h6000, 16'h0000, 16'h8000},
   parameter logic [16*N_SLAVES-1:0]  SLV_MASK = {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hC000, 16'h8000},
   parameter logic [4*N_SLAVES-1:0]   SLV_WAIT = '0,
   parameter logic [7:0]              OPEN_BUS = 8'hFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              cpu_addr,
   input  logic                     cpu_we,
   input  logic [7:0]               cpu_do,
   output logic [7:0]               cpu_di,
   output logic                     cpu_rdy,
   output logic [15:0]              slv_addr,
   output logic                     slv_we,
   output logic [7:0]               slv_wdata,
   output logic [N_SLAVES-1:0]      slv_cs,
   input  logic [8*N_SLAVES-1:0]    slv_rdata,
   input  logic [N_SLAVES-1:0]      slv_irq_n,
   output logic                     cpu_irq
`ifdef BUS_FABRIC_DECERR_EN
   ,
   output logic                     dec_err,
   output logic [15:0]              dec_err_addr
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [15:0]          r_addr;
   logic                 r_we_q;
   logic [7:0]           r_wdata;
   logic [3:0]           r_wait_cnt;
   logic [3:0]           w_wait_nxt;
   logic [N_SLAVES-1:0]  w_cap_sel;
   logic [N_SLAVES-1:0]  w_addr_sel;
   logic [N_SLAVES-1:0]  w_cur_sel;
   logic                 w_rdy;
   logic                 w_any_sel;

   // Descending scan: the last hit written is the lowest index, so it wins.
   function automatic logic [N_SLAVES-1:0] decode(input logic [15:0] addr);
      decode = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[16*i +: 16]) == SLV_BASE[16*i +: 16]) begin
            decode    = '0;
            decode[i] = 1'b1;
         end
      end
   endfunction

   function automatic logic [3:0] wait_of(input logic [N_SLAVES-1:0] sel);
      wait_of = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (sel[i]) begin
            wait_of = wait_of | SLV_WAIT[4*i +: 4];
         end
      end
   endfunction

   function automatic logic [7:0] rdata_of(input logic [N_SLAVES-1:0] sel,
                                           input logic [8*N_SLAVES-1:0] rdata);
      rdata_of = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (sel[i]) begin
            rdata_of = rdata_of | rdata[8*i +: 8];
         end
      end
   endfunction

   assign w_cap_sel  = decode(cpu_addr);
   assign w_addr_sel = decode(r_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_we_q     <= 1'b0;
         r_wdata    <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_rdy) begin
            r_addr  <= cpu_addr;
            r_we_q  <= cpu_we;
            r_wdata <= cpu_do;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_rdy       = 1'b1;
      w_cur_sel   = '0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_ACCESS;
            w_wait_nxt  = wait_of(w_cap_sel);
         end
         ST_ACCESS: begin
            w_cur_sel = w_addr_sel;
            w_rdy     = (r_wait_cnt == 4'd0);
            if (w_rdy) begin
               w_wait_nxt = wait_of(w_cap_sel);
            end else begin
               w_wait_nxt = r_wait_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_any_sel = |w_cur_sel;

   assign slv_addr  = r_addr;
   assign slv_wdata = r_wdata;
   assign slv_cs    = w_cur_sel;
   assign cpu_rdy   = w_rdy;
   assign slv_we    = r_we_q & w_rdy & w_any_sel;
   assign cpu_di    = w_any_sel ? rdata_of(w_cur_sel, slv_rdata) : OPEN_BUS;
   assign cpu_irq   = ~(&slv_irq_n);

`ifdef BUS_FABRIC_DECERR_EN
   logic        r_dec_err;
   logic [15:0] r_dec_err_addr;

   // Only the first unmapped completion is recorded until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dec_err      <= 1'b0;
         r_dec_err_addr <= '0;
      end else if ((r_state == ST_ACCESS) && w_rdy && !w_any_sel && !r_dec_err) begin
         r_dec_err      <= 1'b1;
         r_dec_err_addr <= r_addr;
      end
   end

   assign dec_err      = r_dec_err;
   assign dec_err_addr = r_dec_err_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_fabric
// Brief    : Directed bench for bus_fabric; a transaction-level model is
//            compared every cycle, plus hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_fabric;

   localparam int NS = 5;
   localparam logic [15:0] M_BASE [NS] = '{16'h8000, 16'h0000, 16'h6000, 16'h7000, 16'h5000};
   localparam logic [15:0] M_MASK [NS] = '{16'h8000, 16'hC000, 16'hFFF0, 16'hFFF0, 16'hFFF0};
   localparam int          M_WAIT [NS] = '{0, 0, 3, 1, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [15:0]       cpu_addr;
   logic              cpu_we;
   logic [7:0]        cpu_do;
   logic [7:0]        cpu_di;
   logic              cpu_rdy;
   logic [15:0]       slv_addr;
   logic              slv_we;
   logic [7:0]        slv_wdata;
   logic [NS-1:0]     slv_cs;
   logic [8*NS-1:0]   slv_rdata;
   logic [NS-1:0]     slv_irq_n;
   logic              cpu_irq;

   logic [7:0]        ov_di;
   logic              ov_rdy;
   logic [15:0]       ov_addr;
   logic              ov_we;
   logic [7:0]        ov_wdata;
   logic [1:0]        ov_cs;
   logic [15:0]       ov_rdata;
   logic [1:0]        ov_irq_n;
   logic              ov_irq;

`ifdef BUS_FABRIC_DECERR_EN
   logic              dec_err;
   logic [15:0]       dec_err_addr;
   logic              ov_dec_err;
   logic [15:0]       ov_dec_err_addr;
`endif

   bus_fabric #(.SLV_WAIT(20'h01300)) dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .slv_addr(slv_addr), .slv_we(slv_we),
      .slv_wdata(slv_wdata), .slv_cs(slv_cs), .slv_rdata(slv_rdata),
      .slv_irq_n(slv_irq_n), .cpu_irq(cpu_irq)
`ifdef BUS_FABRIC_DECERR_EN
      , .dec_err(dec_err), .dec_err_addr(dec_err_addr)
`endif
   );

   // Two-region instance whose regions overlap at 0010-001F.
   bus_fabric #(
      .N_SLAVES(2),
      .SLV_BASE({16'h0000, 16'h0010}),
      .SLV_MASK({16'hC000, 16'hFFF0}),
      .SLV_WAIT(8'h00)
   ) u_ovl (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .cpu_di(ov_di), .cpu_rdy(ov_rdy), .slv_addr(ov_addr), .slv_we(ov_we),
      .slv_wdata(ov_wdata), .slv_cs(ov_cs), .slv_rdata(ov_rdata),
      .slv_irq_n(ov_irq_n), .cpu_irq(ov_irq)
`ifdef BUS_FABRIC_DECERR_EN
      , .dec_err(ov_dec_err), .dec_err_addr(ov_dec_err_addr)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the access in flight, how many wait cycles it still owes.
   function automatic int region_of(input logic [15:0] a);
      for (int i = 0; i < NS; i++) begin
         if ((a & M_MASK[i]) == M_BASE[i]) return i;
      end
      return -1;
   endfunction

   function automatic int waits_for(input logic [15:0] a);
      int r;
      r = region_of(a);
      return (r < 0) ? 0 : M_WAIT[r];
   endfunction

   logic        m_valid = 1'b0;
   logic        m_started;
   logic [15:0] m_addr;
   logic        m_we;
   logic [7:0]  m_data;
   int          m_left;
   logic        m_err;
   logic [15:0] m_err_addr;

   int          e_reg;
   logic [NS-1:0] e_cs;
   logic        e_rdy;
   logic        e_we;
   logic [7:0]  e_di;
   logic        e_irq;

   always_comb begin
      e_reg = m_started ? region_of(m_addr) : -1;
      e_cs  = '0;
      e_di  = 8'hFF;
      if (e_reg >= 0) begin
         e_cs = 5'b00001 << e_reg;
         e_di = slv_rdata[8*e_reg +: 8];
      end
      e_rdy = (m_left == 0);
      e_we  = m_we && e_rdy && (e_reg >= 0);
      e_irq = (slv_irq_n != 5'b11111);
   end

   always @(posedge clk) begin
      if (reset) begin
         m_valid    <= 1'b1;
         m_started  <= 1'b0;
         m_addr     <= '0;
         m_we       <= 1'b0;
         m_data     <= '0;
         m_left     <= 0;
         m_err      <= 1'b0;
         m_err_addr <= '0;
      end else if (m_valid) begin
         if (m_started && e_reg < 0 && !m_err) begin
            m_err      <= 1'b1;
            m_err_addr <= m_addr;
         end
         m_started <= 1'b1;
         if (m_left == 0) begin
            m_addr <= cpu_addr;
            m_we   <= cpu_we;
            m_data <= cpu_do;
            m_left <= waits_for(cpu_addr);
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cs", 32'(slv_cs), 32'(e_cs));
         check("rdy", 32'(cpu_rdy), 32'(e_rdy));
         check("we", 32'(slv_we), 32'(e_we));
         check("di", 32'(cpu_di), 32'(e_di));
         check("slv_addr", 32'(slv_addr), 32'(m_addr));
         check("wdata", 32'(slv_wdata), 32'(m_data));
         check("irq", 32'(cpu_irq), 32'(e_irq));
`ifdef BUS_FABRIC_DECERR_EN
         check("dec_err", 32'(dec_err), 32'(m_err));
         check("dec_err_addr", 32'(dec_err_addr), 32'(m_err_addr));
`endif
      end
   end

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   // Present an access; scribble on the bus while the fabric is stalled.
   task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] d);
      for (int k = 0; k < 32; k++) begin
         if (m_left == 0) begin
            cpu_addr = a;
            cpu_we   = w;
            cpu_do   = d;
            @(posedge clk);
            #2;
            return;
         end
         cpu_addr = 16'($urandom);
         cpu_we   = 1'($urandom);
         cpu_do   = 8'($urandom);
         @(posedge clk);
         #2;
      end
      n_checks++;
      n_err++;
      $display("FAIL access_timeout: addr %0h never accepted", a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cpu_addr  = 16'h8123;
      cpu_we    = 1'b0;
      cpu_do    = 8'h00;
      slv_irq_n = 5'b11111;
      ov_irq_n  = 2'b11;
      slv_rdata = {8'h7E, 8'h96, 8'hC3, 8'h5A, 8'hA5};
      ov_rdata  = 16'hBEEF;
      repeat (3) @(posedge clk);
      #2;

      at_neg();
      check("rst_addr", 32'(slv_addr), 32'h0000);
      check("rst_wdata", 32'(slv_wdata), 32'h00);
      check("rst_cs", 32'(slv_cs), 32'h00);
      check("rst_we", 32'(slv_we), 32'h0);
      check("rst_rdy", 32'(cpu_rdy), 32'h1);
      check("rst_di", 32'(cpu_di), 32'hFF);
      reset = 1'b0;

      do_access(16'h8123, 1'b0, 8'h00);
      at_neg();
      check("rd8123_cs", 32'(slv_cs), 32'h01);
      check("rd8123_rdy", 32'(cpu_rdy), 32'h1);
      check("rd8123_di", 32'(cpu_di), 32'hA5);

      do_access(16'h0010, 1'b1, 8'h11);
      at_neg();
      check("ovl_cs_0010", 32'(ov_cs), 32'h1);
      check("ovl_di_0010", 32'(ov_di), 32'hEF);
      check("ovl_we_0010", 32'(ov_we), 32'h1);
      check("ovl_addr", 32'(ov_addr), 32'h0010);
      check("ovl_wdata", 32'(ov_wdata), 32'h11);
      check("main_cs_0010", 32'(slv_cs), 32'h02);
      check("main_we_0010", 32'(slv_we), 32'h1);
      check("ovl_irq", 32'(ov_irq), 32'h0);
`ifdef BUS_FABRIC_DECERR_EN
      check("ovl_dec_err", 32'(ov_dec_err), 32'h1);
      check("ovl_dec_err_addr", 32'(ov_dec_err_addr), 32'h8123);
`endif

      do_access(16'h0020, 1'b0, 8'h00);
      at_neg();
      check("ovl_cs_0020", 32'(ov_cs), 32'h2);
      check("ovl_di_0020", 32'(ov_di), 32'hBE);
      check("ovl_rdy", 32'(ov_rdy), 32'h1);

      do_access(16'h5004, 1'b1, 8'h22);
      do_access(16'h7003, 1'b0, 8'h00);
      do_access(16'hF00F, 1'b1, 8'h33);
      do_access(16'h6001, 1'b1, 8'h3C);
      for (int k = 0; k < 4; k++) begin
         cpu_addr = 16'h1230 + 16'(k);
         cpu_we   = 1'b0;
         at_neg();
         check("w6001_rdy", 32'(cpu_rdy), (k == 3) ? 32'h1 : 32'h0);
         check("w6001_we", 32'(slv_we), (k == 3) ? 32'h1 : 32'h0);
         check("w6001_addr", 32'(slv_addr), 32'h6001);
         check("w6001_cs", 32'(slv_cs), 32'h04);
         check("w6001_wdata", 32'(slv_wdata), 32'h3C);
         @(posedge clk);
         #2;
      end

      do_access(16'h4000, 1'b0, 8'h00);
      at_neg();
      check("unmap_cs", 32'(slv_cs), 32'h00);
      check("unmap_di", 32'(cpu_di), 32'hFF);
      check("unmap_rdy", 32'(cpu_rdy), 32'h1);
      do_access(16'h4000, 1'b1, 8'h55);
      at_neg();
      check("unmap_we", 32'(slv_we), 32'h0);
`ifdef BUS_FABRIC_DECERR_EN
      check("decerr_set", 32'(dec_err), 32'h1);
      check("decerr_addr", 32'(dec_err_addr), 32'h4000);
`endif
      do_access(16'h4ABC, 1'b0, 8'h00);
      do_access(16'h0100, 1'b0, 8'h00);
      at_neg();
`ifdef BUS_FABRIC_DECERR_EN
      check("decerr_sticky", 32'(dec_err_addr), 32'h4000);
`endif
      check("rd0100_di", 32'(cpu_di), 32'h5A);

      slv_irq_n = 5'b11011;
      #1;
      check("irq_one", 32'(cpu_irq), 32'h1);
      slv_irq_n = 5'b11111;
      #1;
      check("irq_none", 32'(cpu_irq), 32'h0);

      do_access(16'h6002, 1'b1, 8'h77);
      @(posedge clk);
      #2;
      reset     = 1'b1;
      slv_irq_n = 5'b11011;
      at_neg();
      check("abort_we", 32'(slv_we), 32'h0);
      check("irq_in_reset", 32'(cpu_irq), 32'h1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      at_neg();
      check("abort_rdy", 32'(cpu_rdy), 32'h1);
      check("abort_cs", 32'(slv_cs), 32'h00);
      check("abort_we2", 32'(slv_we), 32'h0);
      slv_irq_n = 5'b11111;

      slv_rdata = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
      for (int n = 0; n < 24; n++) begin
         logic [15:0] a;
         case (n % 6)
            0: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            1: a = 16'($urandom_range(0, 16'h3FFF));
            2: a = 16'h6000 | 16'($urandom_range(0, 15));
            3: a = 16'h7000 | 16'($urandom_range(0, 15));
            4: a = 16'h5000 | 16'($urandom_range(0, 15));
            default: a = 16'h4000 | 16'($urandom_range(0, 16'h0FFF));
         endcase
         do_access(a, 1'($urandom), 8'($urandom));
      end

      repeat (6) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
